uart_debug_ctrl: RTL and testbench



---
 rtl/uart_debug_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_uart_debug_ctrl.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_debug_ctrl.sv
// uart_debug_ctrl: UART command sequencer for CPU step/run/halt and word dump.
// Ports: clk/reset; RX FIFO (rx_empty, r_data, rd_uart); TX FIFO (tx_full,
//   w_data, wr_uart); CPU (cpu_step, cpu_run, cpu_halted); dump bank
//   (dump_idx, dump_data); busy. Define DUMP_CHECKSUM_EN for an XOR sum byte.
module uart_debug_ctrl #(
    parameter int         NUM_WORDS = 32,
    parameter int         IDX_W     = 5,
    parameter logic [7:0] ACK_BYTE  = 8'h06,
    parameter logic [7:0] NAK_BYTE  = 8'h15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [7:0]       r_data,
    output logic             rd_uart,
    input  logic             tx_full,
    output logic [7:0]       w_data,
    output logic             wr_uart,
    output logic             cpu_step,
    output logic             cpu_run,
    input  logic             cpu_halted,
    output logic [IDX_W-1:0] dump_idx,
    input  logic [31:0]      dump_data,
    output logic             busy
);

    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_HALT = 8'h48;
    localparam logic [7:0] CMD_DUMP = 8'h44;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_STEP,
        S_RUN,
        S_DUMP_LOAD,
        S_DUMP_SEND,
        S_DUMP_END,
`ifdef DUMP_CHECKSUM_EN
        S_SEND_SUM,
`endif
        S_SEND_ACK,
        S_SEND_NAK
    } state_t;

    state_t           state_q;
    logic [7:0]       cmd_q;
    logic             rd_q;
    logic             wr_q;
    logic [7:0]       wdata_q;
    logic             step_q;
    logic             run_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      shreg_q;
    logic [1:0]       bcnt_q;
    logic             wait_q;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]       sum_q;
`endif

    // Strobes are registered, so the FIFO flags seen this cycle do not yet
    // reflect a pop/push issued last cycle; never issue a second one while
    // the previous strobe is still on the wire.
    logic rx_ok;
    logic tx_ok;
    assign rx_ok = !rx_empty && !rd_q;
    assign tx_ok = !tx_full && !wr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            step_q  <= 1'b0;
            run_q   <= 1'b0;
            idx_q   <= '0;
            shreg_q <= '0;
            bcnt_q  <= '0;
            wait_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            step_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rx_ok) begin
                        cmd_q   <= r_data;
                        rd_q    <= 1'b1;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    unique case (1'b1)
                        cmd_q == CMD_STEP: state_q <= S_STEP;
                        cmd_q == CMD_RUN: begin
                            run_q   <= 1'b1;
                            state_q <= S_RUN;
                        end
                        cmd_q == CMD_DUMP: begin
                            idx_q   <= '0;
                            bcnt_q  <= '0;
                            wait_q  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                            sum_q   <= '0;
`endif
                            state_q <= S_DUMP_LOAD;
                        end
                        cmd_q == CMD_HALT: state_q <= S_SEND_ACK;
                        default: state_q <= S_SEND_NAK;
                    endcase
                end
                S_STEP: begin
                    step_q  <= 1'b1;
                    state_q <= S_SEND_ACK;
                end
                S_RUN: begin
                    // Halt has priority; a byte pending alongside it stays
                    // in the FIFO.
                    if (cpu_halted) begin
                        run_q   <= 1'b0;
                        state_q <= S_SEND_ACK;
                    end else if (rx_ok) begin
                        rd_q <= 1'b1;
                        if (r_data == CMD_HALT) begin
                            run_q   <= 1'b0;
                            state_q <= S_SEND_ACK;
                        end
                    end
                end
                S_DUMP_LOAD: begin
                    // dump_data is a registered read of dump_idx: the word
                    // for a new index is only valid on the second cycle.
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                    end else begin
                        wait_q  <= 1'b0;
                        shreg_q <= dump_data;
                        state_q <= S_DUMP_SEND;
                    end
                end
                S_DUMP_SEND: begin
                    if (tx_ok) begin
                        wr_q    <= 1'b1;
                        wdata_q <= shreg_q[31:24];
                        shreg_q <= {shreg_q[23:0], 8'h00};
                        bcnt_q  <= bcnt_q + 2'd1;
`ifdef DUMP_CHECKSUM_EN
                        sum_q   <= sum_q ^ shreg_q[31:24];
`endif
                        if (bcnt_q == 2'd3) begin
                            if (idx_q == LAST_IDX) begin
                                state_q <= S_DUMP_END;
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= S_DUMP_LOAD;
                            end
                        end
                    end
                end
                S_DUMP_END: begin
`ifdef DUMP_CHECKSUM_EN
                    state_q <= S_SEND_SUM;
`else
                    state_q <= S_SEND_ACK;
`endif
                end
`ifdef DUMP_CHECKSUM_EN
                S_SEND_SUM: begin
                    if (tx_ok) begin
                        wr_q    <= 1'b1;
                        wdata_q <= sum_q;
                        state_q <= S_SEND_ACK;
                    end
                end
`endif
                S_SEND_ACK: begin
                    if (tx_ok) begin
                        wr_q    <= 1'b1;
                        wdata_q <= ACK_BYTE;
                        state_q <= S_IDLE;
                    end
                end
                S_SEND_NAK: begin
                    if (tx_ok) begin
                        wr_q    <= 1'b1;
                        wdata_q <= NAK_BYTE;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_uart  = rd_q;
    assign wr_uart  = wr_q;
    assign w_data   = wdata_q;
    assign cpu_step = step_q;
    assign cpu_run  = run_q;
    assign dump_idx = idx_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb_uart_debug_ctrl: bench for uart_debug_ctrl with modelled RX/TX FIFOs,
// a registered dump-word source and a command-level reference model.
`timescale 1ns/1ps
module tb_uart_debug_ctrl;

    localparam int NW = 4;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_empty = 1'b1;
    logic [7:0]    r_data = 8'h00;
    logic          rd_uart;
    logic          tx_full = 1'b0;
    logic [7:0]    w_data;
    logic          wr_uart;
    logic          cpu_step;
    logic          cpu_run;
    logic          cpu_halted = 1'b0;
    logic [IW-1:0] dump_idx;
    logic [31:0]   dump_data;
    logic          busy;

    always #5 clk = ~clk;

    uart_debug_ctrl #(.NUM_WORDS(NW), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset),
        .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
        .cpu_step(cpu_step), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .dump_idx(dump_idx), .dump_data(dump_data), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txlog[$];
    int          tx_cnt = 0;
    int          drain_mode = 0;
    int          cyc = 0;
    logic [31:0] salt = 32'h0;
    int          rd_cnt = 0;
    int          step_cnt = 0;
    int          run_cycles = 0;
    logic        step_prev = 1'b0;
    logic        rd_seen = 1'b0;
    logic        wr_seen = 1'b0;
    logic        dr;

    function automatic logic [31:0] word_of(int i);
        logic [7:0] k;
        k = 8'(i);
        return {8'hA0 + k, 8'hB0 + k, 8'hC0 + k, 8'hD0 + k} ^ salt;
    endfunction

    always @(posedge clk) dump_data <= word_of(int'(dump_idx));

    task automatic rx_upd();
        rx_empty = (rxq.size() == 0);
        r_data = rx_empty ? 8'h00 : rxq[0];
    endtask

    // Observe the DUT mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (rd_uart === 1'b1) begin
            checks++;
            if (rx_empty) begin
                errors++;
                $display("FAIL rd_guard: rd_uart=1 with rx_empty=%0b, required 0",
                         rx_empty);
            end
            rd_cnt++;
        end
        if (wr_uart === 1'b1) begin
            checks++;
            if (tx_full) begin
                errors++;
                $display("FAIL wr_guard: wr_uart=1 with tx_full=%0b, required 0",
                         tx_full);
            end
            txlog.push_back(w_data);
        end
        if (cpu_step === 1'b1) begin
            checks++;
            if (step_prev) begin
                errors++;
                $display("FAIL step_width: cpu_step high 2 cycles, required 1");
            end
            step_cnt++;
        end
        step_prev = (cpu_step === 1'b1);
        if (cpu_run === 1'b1) run_cycles++;
        rd_seen = (rd_uart === 1'b1);
        wr_seen = (wr_uart === 1'b1);
    end

    // FIFO state updates just after the edge, like registered FIFO flags.
    always @(posedge clk) begin
        #1;
        if (rd_seen && rxq.size() > 0) void'(rxq.pop_front());
        rd_seen = 1'b0;
        case (drain_mode)
            0: dr = 1'b1;
            1: dr = ((cyc / 3) % 2) == 0;
            default: dr = 1'($urandom_range(0, 1));
        endcase
        if (dr && tx_cnt > 0) tx_cnt--;
        if (wr_seen) tx_cnt++;
        wr_seen = 1'b0;
        tx_full = (tx_cnt >= 2);
        rx_upd();
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b);
        tick();
        rxq.push_back(b);
        rx_upd();
    endtask

    task automatic clr();
        txlog.delete();
        rd_cnt = 0;
        step_cnt = 0;
        run_cycles = 0;
    endtask

    task automatic wait_tx(input int n, input int budget, output bit to);
        int k;
        k = 0;
        while (txlog.size() < n && k < budget) begin
            tick();
            k++;
        end
        to = (txlog.size() < n);
    endtask

    task automatic exp_dump(inout logic [7:0] q[$]);
        logic [31:0] w;
        logic [7:0]  s;
        s = 8'h00;
        for (int i = 0; i < NW; i++) begin
            w = word_of(i);
            for (int b = 3; b >= 0; b--) begin
                q.push_back(w[b*8 +: 8]);
                s = s ^ w[b*8 +: 8];
            end
        end
`ifdef DUMP_CHECKSUM_EN
        q.push_back(s);
`endif
        q.push_back(8'h06);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({rd_uart, wr_uart, w_data, cpu_step, cpu_run, dump_idx, busy}
            !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b run=%b idx=%0d, required 0",
                     busy, cpu_run, dump_idx);
        end
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || wr_uart !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b wr=%b, required 0 0",
                     busy, wr_uart);
        end
    endtask

    task automatic test_step();
        bit to;
        clr();
        send(8'h53);
        wait_tx(1, 50, to);
        repeat (6) tick();
        checks++;
        if (to || txlog.size() != 1 || txlog[0] !== 8'h06) begin
            errors++;
            $display("FAIL step_ack: %0d bytes first %h, required 1 byte 06",
                     txlog.size(), to ? 8'hxx : txlog[0]);
        end
        checks++;
        if (rd_cnt != 1) begin
            errors++;
            $display("FAIL step_pop: %0d pops, required 1", rd_cnt);
        end
        checks++;
        if (step_cnt != 1) begin
            errors++;
            $display("FAIL step_pulse: %0d pulses, required 1", step_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL step_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_run_halt();
        bit to;
        int k;
        int low;
        clr();
        send(8'h52);
        k = 0;
        while (cpu_run !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        checks++;
        if (cpu_run !== 1'b1) begin
            errors++;
            $display("FAIL run_start: cpu_run=%b, required 1", cpu_run);
        end
        low = 0;
        repeat (50) begin
            tick();
            if (cpu_run !== 1'b1) low++;
        end
        checks++;
        if (low != 0) begin
            errors++;
            $display("FAIL run_level: low %0d of 50 cycles, required 0", low);
        end
        cpu_halted = 1'b1;
        tick();
        checks++;
        if (cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL run_drop: cpu_run=%b after halt, required 0", cpu_run);
        end
        cpu_halted = 1'b0;
        wait_tx(1, 50, to);
        repeat (6) tick();
        checks++;
        if (to || txlog.size() != 1 || txlog[0] !== 8'h06) begin
            errors++;
            $display("FAIL run_ack: %0d bytes, required 1 byte 06",
                     txlog.size());
        end
    endtask

    task automatic test_run_discard();
        bit to;
        int k;
        clr();
        send(8'h52);
        k = 0;
        while (cpu_run !== 1'b1 && k < 30) begin
            tick();
            k++;
        end
        send(8'h41);
        repeat (5) tick();
        checks++;
        if (rxq.size() != 0 || cpu_run !== 1'b1 || txlog.size() != 0) begin
            errors++;
            $display("FAIL run_discard: rxq=%0d run=%b tx=%0d, required 0 1 0",
                     rxq.size(), cpu_run, txlog.size());
        end
        send(8'h48);
        wait_tx(1, 50, to);
        repeat (6) tick();
        checks++;
        if (to || txlog.size() != 1 || txlog[0] !== 8'h06 ||
            cpu_run !== 1'b0) begin
            errors++;
            $display("FAIL run_h_ack: %0d bytes run=%b, required 1 byte 0",
                     txlog.size(), cpu_run);
        end
        checks++;
        if (rd_cnt != 3) begin
            errors++;
            $display("FAIL run_pops: %0d pops, required 3", rd_cnt);
        end
    endtask

    task automatic test_unknown();
        bit to;
        clr();
        send(8'h7F);
        wait_tx(1, 50, to);
        repeat (6) tick();
        checks++;
        if (to || txlog.size() != 1 || txlog[0] !== 8'h15) begin
            errors++;
            $display("FAIL nak: %0d bytes, required 1 byte 15", txlog.size());
        end
        checks++;
        if (step_cnt != 0 || run_cycles != 0) begin
            errors++;
            $display("FAIL nak_cpu: steps=%0d run=%0d, required 0 0",
                     step_cnt, run_cycles);
        end
    endtask

    task automatic test_dump(input string tag);
        logic [7:0] exp[$];
        bit to;
        int bad;
        clr();
        exp_dump(exp);
        send(8'h44);
        wait_tx(exp.size(), 3000, to);
        repeat (12) tick();
        bad = -1;
        for (int i = 0; i < exp.size() && bad < 0; i++)
            if (i >= txlog.size() || txlog[i] !== exp[i]) bad = i;
        if (bad < 0 && txlog.size() != exp.size()) bad = exp.size();
        checks++;
        if (to || bad >= 0) begin
            errors++;
            $display("FAIL %s: %0d bytes, first bad at %0d, required %0d bytes",
                     tag, txlog.size(), bad, exp.size());
        end
        checks++;
        if (dump_idx !== IW'(NW - 1) || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idx: idx=%0d busy=%b, required %0d 0",
                     tag, dump_idx, busy, NW - 1);
        end
    endtask

    task automatic test_reset_mid_dump();
        int k;
        int n;
        clr();
        drain_mode = 1;
        send(8'h44);
        k = 0;
        while (txlog.size() < 5 && k < 300) begin
            tick();
            k++;
        end
        checks++;
        if (txlog.size() < 5) begin
            errors++;
            $display("FAIL mid_dump_start: %0d bytes, required 5", txlog.size());
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({rd_uart, wr_uart, w_data, cpu_step, cpu_run, dump_idx, busy}
            !== '0) begin
            errors++;
            $display("FAIL mid_reset_out: wr=%b idx=%0d busy=%b, required 0",
                     wr_uart, dump_idx, busy);
        end
        n = txlog.size();
        repeat (3) tick();
        reset = 1'b0;
        repeat (20) tick();
        checks++;
        if (txlog.size() != n) begin
            errors++;
            $display("FAIL mid_reset_quiet: %0d bytes after reset, required 0",
                     txlog.size() - n);
        end
        test_dump("dump_restart");
        drain_mode = 0;
    endtask

    task automatic test_back_to_back();
        bit to;
        clr();
        send(8'h53);
        send(8'h7F);
        send(8'h48);
        wait_tx(3, 100, to);
        repeat (6) tick();
        checks++;
        if (to || txlog.size() != 3 || txlog[0] !== 8'h06 ||
            txlog[1] !== 8'h15 || txlog[2] !== 8'h06) begin
            errors++;
            $display("FAIL b2b: %0d bytes, required 06 15 06", txlog.size());
        end
        checks++;
        if (step_cnt != 1 || run_cycles != 0) begin
            errors++;
            $display("FAIL b2b_cpu: steps=%0d run=%0d, required 1 0",
                     step_cnt, run_cycles);
        end
    endtask

    function automatic logic [7:0] rand_unknown();
        logic [7:0] b;
        b = 8'($urandom);
        while (b inside {8'h53, 8'h52, 8'h48, 8'h44}) b = 8'($urandom);
        return b;
    endfunction

    task automatic test_random();
        logic [7:0] cmds[$];
        logic [7:0] exp[$];
        logic [7:0] j;
        int exp_steps;
        int bad;
        bit to;
        for (int t = 0; t < 3; t++) begin
            cmds.delete();
            exp.delete();
            exp_steps = 0;
            salt = $urandom;
            drain_mode = 2;
            for (int c = 0; c < 10; c++) begin
                case ($urandom_range(0, 4))
                    0: begin
                        cmds.push_back(8'h53);
                        exp_steps++;
                        exp.push_back(8'h06);
                    end
                    1: begin
                        cmds.push_back(8'h48);
                        exp.push_back(8'h06);
                    end
                    2: begin
                        cmds.push_back(8'h44);
                        exp_dump(exp);
                    end
                    3: begin
                        cmds.push_back(rand_unknown());
                        exp.push_back(8'h15);
                    end
                    default: begin
                        cmds.push_back(8'h52);
                        for (int q = $urandom_range(0, 2); q > 0; q--) begin
                            j = 8'($urandom);
                            if (j == 8'h48) j = 8'h53;
                            cmds.push_back(j);
                        end
                        cmds.push_back(8'h48);
                        exp.push_back(8'h06);
                    end
                endcase
            end
            clr();
            foreach (cmds[i]) send(cmds[i]);
            wait_tx(exp.size(), 8000, to);
            repeat (12) tick();
            bad = -1;
            for (int i = 0; i < exp.size() && bad < 0; i++)
                if (i >= txlog.size() || txlog[i] !== exp[i]) bad = i;
            if (bad < 0 && txlog.size() != exp.size()) bad = exp.size();
            checks++;
            if (to || bad >= 0) begin
                errors++;
                $display("FAIL rand_stream[%0d]: %0d bytes bad at %0d, need %0d",
                         t, txlog.size(), bad, exp.size());
            end
            checks++;
            if (step_cnt != exp_steps) begin
                errors++;
                $display("FAIL rand_steps[%0d]: %0d, required %0d",
                         t, step_cnt, exp_steps);
            end
            checks++;
            if (rxq.size() != 0 || cpu_run !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_end[%0d]: rxq=%0d run=%b busy=%b, need 0",
                         t, rxq.size(), cpu_run, busy);
            end
        end
        salt = 32'h0;
        drain_mode = 0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_halt();
        test_run_discard();
        test_unknown();
        drain_mode = 1;
        test_dump("dump_stream");
        drain_mode = 0;
        test_reset_mid_dump();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
